// File: rtl/pc_predict_ctrlr.sv
// pc_predict_ctrlr: fetch-stage next-PC controller.
// It holds the fetch PC and predicts the next fetch address from a
// direct-mapped BTB with 2-bit saturating counters. It also resolves
// branches and jumps reported by execute. A wrong prediction raises a
// combinational flush and redirects fetch.
module pc_predict_ctrlr #(
    parameter int              XLEN      = 32,
    parameter int              BTB_DEPTH = 16,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            w_stall,
    input  logic            w_resolve_valid,
    input  logic            w_branch_op,
    input  logic            w_jump_op,
    input  logic            w_imm_op,
    input  logic            w_success,
    input  logic [XLEN-1:0] w_epc_in,
    input  logic [XLEN-1:0] w_alu_imm,
    input  logic [25:0]     w_br_imm_26,
    input  logic [XLEN-1:0] w_reg_pc,
    input  logic            w_pred_taken_in,
    input  logic [XLEN-1:0] w_pred_target_in,
    output logic [XLEN-1:0] w_pc_out,
    output logic            w_pred_taken_out,
    output logic [XLEN-1:0] w_pred_target_out,
    output logic            w_flush,
    output logic [XLEN-1:0] w_redirect_pc,
    output logic [15:0]     w_mispredict_cnt
);

    localparam int IDX  = $clog2(BTB_DEPTH);
    localparam int TAGW = XLEN - 2 - IDX;

    // Fetch PC and mispredict counter
    logic [XLEN-1:0] pc_q, pc_d;
    logic [15:0]     missCnt_q, missCnt_d;

    // BTB storage
    logic            btbValid_q  [BTB_DEPTH];
    logic [TAGW-1:0] btbTag_q    [BTB_DEPTH];
    logic [XLEN-1:0] btbTarget_q [BTB_DEPTH];
    logic [1:0]      btbCtr_q    [BTB_DEPTH];

    // Lookup side, driven by the current fetch PC
    logic [IDX-1:0]  lookupIdx;
    logic            lookupHit;

    // Resolve side, driven by the op coming back from execute
    logic [XLEN-1:0] slotPc;
    logic [XLEN-1:0] fallThroughPc;
    logic [XLEN-1:0] actualTarget;
    logic            actualTaken;
    logic [XLEN-1:0] actualNext;
    logic            isCtrlOp;
    logic            mispredict;
    logic            doUpdate;
    logic [IDX-1:0]  updateIdx;
    logic [TAGW-1:0] updateTag;
    logic            updateHit;

    assign lookupIdx = pc_q[2+IDX-1:2];
    assign lookupHit = btbValid_q[lookupIdx] && (btbTag_q[lookupIdx] == pc_q[XLEN-1:2+IDX]);

    assign w_pc_out          = pc_q;
    assign w_pred_taken_out  = lookupHit && btbCtr_q[lookupIdx][1];
    assign w_pred_target_out = lookupHit ? btbTarget_q[lookupIdx] : '0;
    assign w_mispredict_cnt  = missCnt_q;

    // Resolve the op: compute the true target and direction, then compare them with the prediction it carried
    always_comb begin
        slotPc        = w_epc_in + XLEN'(4);
        fallThroughPc = w_epc_in + XLEN'(8);
        if (w_jump_op) begin
            if (w_imm_op) begin
                actualTarget = {slotPc[XLEN-1:28], w_br_imm_26, 2'b00};
            end else begin
                actualTarget = w_reg_pc;
            end
        end else begin
            actualTarget = slotPc + w_alu_imm;
        end
        actualTaken = (w_branch_op && w_success) || w_jump_op;
        actualNext  = actualTaken ? actualTarget : fallThroughPc;
        isCtrlOp    = w_branch_op || w_jump_op;
        doUpdate    = w_resolve_valid && isCtrlOp;
        mispredict  = doUpdate &&
                      ((actualTaken != w_pred_taken_in) ||
                       (actualTaken && (actualTarget != w_pred_target_in)));
        updateIdx   = w_epc_in[2+IDX-1:2];
        updateTag   = w_epc_in[XLEN-1:2+IDX];
        updateHit   = btbValid_q[updateIdx] && (btbTag_q[updateIdx] == updateTag);
    end

    assign w_flush       = mispredict;
    assign w_redirect_pc = mispredict ? actualNext : '0;

    // Next fetch PC: a redirect beats a stall, a stall beats a prediction, and a prediction beats sequential fetch
    always_comb begin
        pc_d = pc_q + XLEN'(4);
        if (mispredict) begin
            pc_d = actualNext;
        end else if (w_stall) begin
            pc_d = pc_q;
        end else if (w_pred_taken_out) begin
            pc_d = w_pred_target_out;
        end
    end

    // The mispredict counter stops at all-ones instead of wrapping
    always_comb begin
        missCnt_d = missCnt_q;
        if (mispredict && (missCnt_q != 16'hFFFF)) begin
            missCnt_d = missCnt_q + 16'd1;
        end
    end

    // PC and counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= RESET_PC;
            missCnt_q <= '0;
        end else begin
            pc_q      <= pc_d;
            missCnt_q <= missCnt_d;
        end
    end

    // BTB training: a hit adjusts the counter, and a taken miss allocates the entry (jumps start strongly taken)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btbValid_q[i]  <= 1'b0;
                btbTag_q[i]    <= '0;
                btbTarget_q[i] <= '0;
                btbCtr_q[i]    <= 2'b00;
            end
        end else if (doUpdate) begin
            if (updateHit) begin
                if (actualTaken) begin
                    btbTarget_q[updateIdx] <= actualTarget;
                    if (btbCtr_q[updateIdx] != 2'b11) begin
                        btbCtr_q[updateIdx] <= btbCtr_q[updateIdx] + 2'b01;
                    end
                end else if (btbCtr_q[updateIdx] != 2'b00) begin
                    btbCtr_q[updateIdx] <= btbCtr_q[updateIdx] - 2'b01;
                end
            end else if (actualTaken) begin
                btbValid_q[updateIdx]  <= 1'b1;
                btbTag_q[updateIdx]    <= updateTag;
                btbTarget_q[updateIdx] <= actualTarget;
                btbCtr_q[updateIdx]    <= w_jump_op ? 2'b11 : 2'b10;
            end
        end
    end

endmodule
